// File: rtl/calc2_port_scheduler.sv
// ---------------------------------------------------------------------------
// calc2_port_scheduler
//
// Purpose:
//   Shares one calc2 add/shift ALU among NUM_PORTS requester ports. Each port
//   runs the calc2 two-cycle request protocol: cmd/op1/tag in the first
//   cycle, op2 in the next. Complete requests are queued per port, one queue
//   head is issued to the ALU per cycle, and each ALU result is routed back
//   to the port that issued it, with its tag.
//
// Handshake (one rule for every port):
//   A cmd is accepted when the port's capture FSM is IDLE, cmd != 0 and
//   req_busy is low in that same cycle. A cmd presented while req_busy is
//   high is dropped without any indication. op2 is taken unconditionally in
//   the cycle after an accepted cmd; cmd is ignored in that cycle.
//
// Ports:
//   c_clk, reset   clock (rising edge) and synchronous active-high reset
//   req_cmd_in     per-port 4-bit cmd: 1=ADD 2=SUB 5=SHL 6=SHR, 0=none
//   req_data_in    per-port op1 (cmd cycle) / op2 (following cycle)
//   req_tag_in     per-port tag, sampled in the cmd cycle
//   req_busy       per-port "cannot accept a cmd this cycle"
//   alu_valid/alu_cmd/alu_op1/alu_op2   registered issue to the shared ALU
//   alu_result/alu_resp                 ALU return, ALU_LAT cycles after issue
//   out_resp/out_data/out_tag           per-port one-cycle response
//
// Configuration macro:
//   CALC2_SCHED_FIXED_PRIO_EN  defined: lowest non-empty port always wins,
//                              no round-robin pointer exists.
//                              undefined (default): round-robin arbitration.
// ---------------------------------------------------------------------------
module calc2_port_scheduler #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 2
) (
    input  logic                        c_clk,
    input  logic                        reset,
    input  logic [NUM_PORTS*4-1:0]      req_cmd_in,
    input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
    input  logic [NUM_PORTS*TAG_W-1:0]  req_tag_in,
    output logic [NUM_PORTS-1:0]        req_busy,
    output logic                        alu_valid,
    output logic [3:0]                  alu_cmd,
    output logic [DATA_W-1:0]           alu_op1,
    output logic [DATA_W-1:0]           alu_op2,
    input  logic [DATA_W-1:0]           alu_result,
    input  logic [1:0]                  alu_resp,
    output logic [NUM_PORTS*2-1:0]      out_resp,
    output logic [NUM_PORTS*DATA_W-1:0] out_data,
    output logic [NUM_PORTS*TAG_W-1:0]  out_tag
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_OP2  = 1'b1
    } cap_state_e;

    typedef struct packed {
        logic [3:0]        cmd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    // Book-keeping that travels alongside an issued slot until its result
    // comes back. inv marks a slot that was granted but never sent to the ALU.
    typedef struct packed {
        logic              vld;
        logic [PORT_W-1:0] port;
        logic [TAG_W-1:0]  tag;
        logic              inv;
    } meta_t;

    // ---------------- capture FSMs ----------------
    cap_state_e        cap_state_q [NUM_PORTS];
    cap_state_e        cap_state_d [NUM_PORTS];
    logic [3:0]        cap_cmd_q   [NUM_PORTS];
    logic [3:0]        cap_cmd_d   [NUM_PORTS];
    logic [DATA_W-1:0] cap_op1_q   [NUM_PORTS];
    logic [DATA_W-1:0] cap_op1_d   [NUM_PORTS];
    logic [TAG_W-1:0]  cap_tag_q   [NUM_PORTS];
    logic [TAG_W-1:0]  cap_tag_d   [NUM_PORTS];

    // ---------------- per-port FIFOs ----------------
    entry_t            fifo_mem_q  [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q    [NUM_PORTS];
    logic [PTR_W-1:0]  wr_ptr_d    [NUM_PORTS];
    logic [PTR_W-1:0]  rd_ptr_q    [NUM_PORTS];
    logic [PTR_W-1:0]  rd_ptr_d    [NUM_PORTS];
    logic [CNT_W-1:0]  count_q     [NUM_PORTS];
    logic [CNT_W-1:0]  count_d     [NUM_PORTS];
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    entry_t            push_entry  [NUM_PORTS];

    // ---------------- arbiter / issue ----------------
    logic              grant_valid;
    logic [PORT_W-1:0] grant_idx;
    entry_t            head;
    logic              head_ok;

    logic              alu_valid_q, alu_valid_d;
    logic [3:0]        alu_cmd_q, alu_cmd_d;
    logic [DATA_W-1:0] alu_op1_q, alu_op1_d;
    logic [DATA_W-1:0] alu_op2_q, alu_op2_d;
    meta_t             iss_meta_q, iss_meta_d;

    // ---------------- return path ----------------
    meta_t             pipe_q [ALU_LAT];
    meta_t             pipe_d [ALU_LAT];
    meta_t             tail;
    logic [NUM_PORTS*2-1:0]      out_resp_q, out_resp_d;
    logic [NUM_PORTS*DATA_W-1:0] out_data_q, out_data_d;
    logic [NUM_PORTS*TAG_W-1:0]  out_tag_q,  out_tag_d;

    // Capture FSM next state, busy and push generation.
    // Busy counts the entry still being assembled in OP2 so that entering
    // OP2 always has a free FIFO slot waiting for it.
    always_comb begin
        logic [CNT_W:0] occ;
        occ = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            cap_state_d[p] = cap_state_q[p];
            cap_cmd_d[p]   = cap_cmd_q[p];
            cap_op1_d[p]   = cap_op1_q[p];
            cap_tag_d[p]   = cap_tag_q[p];
            push[p]        = 1'b0;
            push_entry[p].cmd = cap_cmd_q[p];
            push_entry[p].op1 = cap_op1_q[p];
            push_entry[p].op2 = req_data_in[p*DATA_W +: DATA_W];
            push_entry[p].tag = cap_tag_q[p];

            occ = {1'b0, count_q[p]} + (CNT_W+1)'(cap_state_q[p] == CAP_OP2);
            req_busy[p] = (occ == (CNT_W+1)'(FIFO_DEPTH));

            case (cap_state_q[p])
                CAP_IDLE: begin
                    if (req_cmd_in[p*4 +: 4] != 4'd0 && !req_busy[p]) begin
                        cap_state_d[p] = CAP_OP2;
                        cap_cmd_d[p]   = req_cmd_in[p*4 +: 4];
                        cap_op1_d[p]   = req_data_in[p*DATA_W +: DATA_W];
                        cap_tag_d[p]   = req_tag_in[p*TAG_W +: TAG_W];
                    end
                end
                CAP_OP2: begin
                    push[p]        = 1'b1;
                    cap_state_d[p] = CAP_IDLE;
                end
                default: cap_state_d[p] = CAP_IDLE;
            endcase
        end
    end

`ifdef CALC2_SCHED_FIXED_PRIO_EN
    // Lowest index with a queued request wins; scanned high to low so the
    // last assignment is the lowest port.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (count_q[p] != '0) begin
                grant_valid = 1'b1;
                grant_idx   = PORT_W'(p);
            end
        end
    end
`else
    logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;

    // Round-robin: first non-empty queue at or after the pointer wins.
    always_comb begin
        int cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            cand = int'(rr_ptr_q) + off;
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
            if (!grant_valid && count_q[PORT_W'(cand)] != '0) begin
                grant_valid = 1'b1;
                grant_idx   = PORT_W'(cand);
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end
`endif

    // FIFO pointer/count update; a same-cycle push and pop leaves count as is.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            pop[p]      = grant_valid && (grant_idx == PORT_W'(p));
            wr_ptr_d[p] = wr_ptr_q[p] + PTR_W'(push[p]);
            rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(pop[p]);
            count_d[p]  = count_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
        end
    end

    // Issue: invalid commands still consume their grant slot and carry an
    // error marker down the return pipe, but never strobe the ALU.
    always_comb begin
        head    = fifo_mem_q[grant_idx][rd_ptr_q[grant_idx]];
        head_ok = (head.cmd == 4'd1) || (head.cmd == 4'd2) ||
                  (head.cmd == 4'd5) || (head.cmd == 4'd6);

        alu_valid_d = grant_valid && head_ok;
        alu_cmd_d   = alu_valid_d ? head.cmd : 4'd0;
        alu_op1_d   = alu_valid_d ? head.op1 : '0;
        alu_op2_d   = alu_valid_d ? head.op2 : '0;

        iss_meta_d  = '0;
        if (grant_valid) begin
            iss_meta_d.vld  = 1'b1;
            iss_meta_d.port = grant_idx;
            iss_meta_d.tag  = head.tag;
            iss_meta_d.inv  = !head_ok;
        end
    end

    // Return pipe: the issue-stage metadata lines up with alu_valid, then
    // ALU_LAT more stages bring it level with alu_result.
    always_comb begin
        pipe_d[0] = iss_meta_q;
        for (int k = 1; k < ALU_LAT; k++) pipe_d[k] = pipe_q[k-1];
        tail = pipe_q[ALU_LAT-1];

        out_resp_d = '0;
        out_data_d = '0;
        out_tag_d  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (tail.vld && tail.port == PORT_W'(p)) begin
                out_resp_d[p*2 +: 2]           = tail.inv ? 2'd2 : alu_resp;
                out_data_d[p*DATA_W +: DATA_W] = tail.inv ? '0 : alu_result;
                out_tag_d[p*TAG_W +: TAG_W]    = tail.tag;
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                cap_state_q[p] <= CAP_IDLE;
                cap_cmd_q[p]   <= '0;
                cap_op1_q[p]   <= '0;
                cap_tag_q[p]   <= '0;
                wr_ptr_q[p]    <= '0;
                rd_ptr_q[p]    <= '0;
                count_q[p]     <= '0;
            end
            alu_valid_q <= 1'b0;
            alu_cmd_q   <= '0;
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            iss_meta_q  <= '0;
            for (int k = 0; k < ALU_LAT; k++) pipe_q[k] <= '0;
            out_resp_q  <= '0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                cap_state_q[p] <= cap_state_d[p];
                cap_cmd_q[p]   <= cap_cmd_d[p];
                cap_op1_q[p]   <= cap_op1_d[p];
                cap_tag_q[p]   <= cap_tag_d[p];
                wr_ptr_q[p]    <= wr_ptr_d[p];
                rd_ptr_q[p]    <= rd_ptr_d[p];
                count_q[p]     <= count_d[p];
            end
            alu_valid_q <= alu_valid_d;
            alu_cmd_q   <= alu_cmd_d;
            alu_op1_q   <= alu_op1_d;
            alu_op2_q   <= alu_op2_d;
            iss_meta_q  <= iss_meta_d;
            for (int k = 0; k < ALU_LAT; k++) pipe_q[k] <= pipe_d[k];
            out_resp_q  <= out_resp_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end

    // Queue storage needs no reset: count/pointers define what is valid.
    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (push[p]) fifo_mem_q[p][wr_ptr_q[p]] <= push_entry[p];
        end
    end

    assign alu_valid = alu_valid_q;
    assign alu_cmd   = alu_cmd_q;
    assign alu_op1   = alu_op1_q;
    assign alu_op2   = alu_op2_q;
    assign out_resp  = out_resp_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_calc2_port_scheduler.sv
// ---------------------------------------------------------------------------
// tb_calc2_port_scheduler
//
// Directed bench for calc2_port_scheduler at default parameters. A small
// behavioural ALU answers alu_valid ALU_LAT cycles later; while idle it
// drives junk so the DUT is seen to ignore it. Cycle 0 of every scenario is
// the cycle in which the first cmd is presented.
// ---------------------------------------------------------------------------
module tb_calc2_port_scheduler;

    localparam int NP  = 4;
    localparam int DW  = 32;
    localparam int TW  = 2;
    localparam int LAT = 2;

    // ---------------- clock / reset ----------------
    logic c_clk = 1'b0;
    logic reset = 1'b1;
    always #5 c_clk = ~c_clk;

    logic [NP*4-1:0]  req_cmd_in  = '0;
    logic [NP*DW-1:0] req_data_in = '0;
    logic [NP*TW-1:0] req_tag_in  = '0;
    logic [NP-1:0]    req_busy;
    logic             alu_valid;
    logic [3:0]       alu_cmd;
    logic [DW-1:0]    alu_op1, alu_op2, alu_result;
    logic [1:0]       alu_resp;
    logic [NP*2-1:0]  out_resp;
    logic [NP*DW-1:0] out_data;
    logic [NP*TW-1:0] out_tag;

    calc2_port_scheduler dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .req_tag_in  (req_tag_in),
        .req_busy    (req_busy),
        .alu_valid   (alu_valid),
        .alu_cmd     (alu_cmd),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_result  (alu_result),
        .alu_resp    (alu_resp),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .out_tag     (out_tag)
    );

    // ---------------- behavioural ALU ----------------
    logic          force_ovf = 1'b0;
    logic          m_v   [LAT];
    logic [DW-1:0] m_res [LAT];

    function automatic logic [DW-1:0] alu_fn(input logic [3:0] c,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (c)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            default: return '0;
        endcase
    endfunction

    initial begin
        for (int k = 0; k < LAT; k++) begin
            m_v[k]   = 1'b0;
            m_res[k] = '0;
        end
    end

    always @(posedge c_clk) begin
        m_v[0]   <= alu_valid;
        m_res[0] <= alu_fn(alu_cmd, alu_op1, alu_op2);
        for (int k = 1; k < LAT; k++) begin
            m_v[k]   <= m_v[k-1];
            m_res[k] <= m_res[k-1];
        end
    end

    assign alu_result = m_v[LAT-1] ? m_res[LAT-1] : 32'hDEAD_BEEF;
    assign alu_resp   = m_v[LAT-1] ? (force_ovf ? 2'd2 : 2'd1) : 2'd3;

    // ---------------- scoreboard ----------------
    int vectors    = 0;
    int miscompares = 0;
    int multi_hits = 0;
    // record: {port[1:0], resp[1:0], tag[1:0], data[31:0]}
    logic [37:0] got_q[$];
    logic [37:0] exp_q[$];

    always @(negedge c_clk) begin
        int hits;
        hits = 0;
        for (int p = 0; p < NP; p++) begin
            if (out_resp[p*2 +: 2] != 2'd0) begin
                hits++;
                got_q.push_back({2'(p), out_resp[p*2 +: 2], out_tag[p*2 +: 2], out_data[p*DW +: DW]});
            end
        end
        if (hits > 1) multi_hits++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_cmd_in  = '0;
        req_data_in = '0;
        req_tag_in  = '0;
    endtask

    task automatic set_port(input int p, input logic [3:0] cmd,
                            input logic [DW-1:0] d, input logic [TW-1:0] t);
        req_cmd_in[p*4 +: 4]    = cmd;
        req_data_in[p*DW +: DW] = d;
        req_tag_in[p*TW +: TW]  = t;
    endtask

    // Leaves the bench in cycle 0 of a fresh scenario.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  req_busy,  '0);
        check({tag, "_valid"}, alu_valid, '0);
        check({tag, "_cmd"},   alu_cmd,   '0);
        check({tag, "_op1"},   alu_op1,   '0);
        check({tag, "_op2"},   alu_op2,   '0);
        check({tag, "_resp"},  out_resp,  '0);
        check({tag, "_data"},  out_data,  '0);
        check({tag, "_tag"},   out_tag,   '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n_exp [NP];
        n_exp = '{7, 7, 6, 6};

        // Reset state
        idle_inputs();
        reset = 1'b1;
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // 1: port2 SUB 0x22-0x3 tag 2
        set_port(2, 4'd2, 32'h22, 2'd2);
        tick();                                      // c1
        set_port(2, 4'd0, 32'h3, 2'd0);
        tick();                                      // c2
        idle_inputs();
        check("t1_valid_c2", alu_valid, 1'b0);
        tick();                                      // c3
        check("t1_valid_c3", alu_valid, 1'b1);
        check("t1_cmd_c3",   alu_cmd,   4'd2);
        check("t1_op1_c3",   alu_op1,   32'h22);
        check("t1_op2_c3",   alu_op2,   32'h3);
        tick();                                      // c4
        check("t1_valid_c4", alu_valid, 1'b0);
        tick();                                      // c5
        check("t1_resp_c5",  out_resp,  8'h00);
        tick();                                      // c6
        check("t1_resp_c6",  out_resp,  8'h10);
        check("t1_data_c6",  out_data,  {32'h0, 32'h1F, 64'h0});
        check("t1_tag_c6",   out_tag,   8'h20);
        tick();                                      // c7
        check("t1_resp_c7",  out_resp,  8'h00);

        // 2: all ports ADD together, round-robin from port 0
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p, 4'd1, 32'(32'h100 * (p + 1)), 2'(p));
        tick();
        for (int p = 0; p < NP; p++) set_port(p, 4'd0, 32'(p + 1), 2'd0);
        tick();                                      // c2
        idle_inputs();
        tick();                                      // c3
        check("t2_valid_c3", alu_valid, 1'b1);
        check("t2_op1_c3",   alu_op1,   32'h100);
        tick();                                      // c4
        check("t2_op1_c4",   alu_op1,   32'h200);
        tick();                                      // c5
        check("t2_op1_c5",   alu_op1,   32'h300);
        tick();                                      // c6
        check("t2_op1_c6",   alu_op1,   32'h400);
        check("t2_resp_c6",  out_resp,  8'h01);
        check("t2_data_c6",  out_data,  {96'h0, 32'h101});
        check("t2_tag_c6",   out_tag,   8'h00);
        tick();                                      // c7
        check("t2_valid_c7", alu_valid, 1'b0);
        check("t2_resp_c7",  out_resp,  8'h04);
        check("t2_data_c7",  out_data,  {64'h0, 32'h202, 32'h0});
        check("t2_tag_c7",   out_tag,   8'h04);
        tick();                                      // c8
        check("t2_resp_c8",  out_resp,  8'h10);
        check("t2_data_c8",  out_data,  {32'h0, 32'h303, 64'h0});
        check("t2_tag_c8",   out_tag,   8'h20);
        tick();                                      // c9
        check("t2_resp_c9",  out_resp,  8'h40);
        check("t2_data_c9",  out_data,  {32'h404, 96'h0});
        check("t2_tag_c9",   out_tag,   8'hC0);
        tick();                                      // c10
        check("t2_resp_c10", out_resp,  8'h00);

        // 4: port1 invalid cmd 3 tag 1 -> no issue, error response
        do_reset();
        set_port(1, 4'd3, 32'h55, 2'd1);
        tick();
        set_port(1, 4'd0, 32'h66, 2'd0);
        tick();
        idle_inputs();
        tick();                                      // c3
        check("t4_valid_c3", alu_valid, 1'b0);
        check("t4_cmd_c3",   alu_cmd,   4'd0);
        tick();
        tick();
        tick();                                      // c6
        check("t4_resp_c6",  out_resp,  8'h08);
        check("t4_data_c6",  out_data,  128'h0);
        check("t4_tag_c6",   out_tag,   8'h04);

        // 5: port3 ADD, ALU reports overflow
        do_reset();
        force_ovf = 1'b1;
        set_port(3, 4'd1, 32'h5, 2'd3);
        tick();
        set_port(3, 4'd0, 32'h7, 2'd0);
        tick();
        idle_inputs();
        tick();                                      // c3
        check("t5_valid_c3", alu_valid, 1'b1);
        check("t5_cmd_c3",   alu_cmd,   4'd1);
        tick();
        tick();
        tick();                                      // c6
        check("t5_resp_c6",  out_resp,  8'h80);
        check("t5_data_c6",  out_data,  {32'hC, 96'h0});
        check("t5_tag_c6",   out_tag,   8'hC0);
        force_ovf = 1'b0;

        // 6: reset with three requests in flight
        do_reset();
        for (int p = 0; p < 3; p++) set_port(p, 4'd1, 32'(p + 1), 2'(p));
        tick();
        for (int p = 0; p < 3; p++) set_port(p, 4'd0, 32'h10, 2'd0);
        tick();                                      // c2
        idle_inputs();
        tick();                                      // c3
        check("t6_valid_c3", alu_valid, 1'b1);
        tick();                                      // c4
        reset = 1'b1;
        tick();                                      // c5
        reset = 1'b0;
        check_all_zero("t6_after_reset");
        for (int c = 6; c <= 12; c++) begin
            tick();
            check("t6_no_resp",  out_resp,  8'h00);
            check("t6_no_valid", alu_valid, 1'b0);
        end

        // 3: all ports stream requests on even cycles 0..12; queues fill,
        //    ports 2 and 3 drop their cycle-12 cmd.
        do_reset();
        got_q.delete();
        for (int c = 0; c <= 14; c++) begin
            if (c == 9)  check("t3_busy_c9",  req_busy, 4'b1000);
            if (c == 10) check("t3_busy_c10", req_busy, 4'b0000);
            if (c == 11) check("t3_busy_c11", req_busy, 4'b1110);
            if (c == 12) check("t3_busy_c12", req_busy, 4'b1100);
            if (c == 13) check("t3_busy_c13", req_busy, 4'b1011);
            if (c == 14) check("t3_busy_c14", req_busy, 4'b0011);
            idle_inputs();
            if (c <= 12) begin
                for (int p = 0; p < NP; p++) begin
                    if (c % 2 == 0) set_port(p, 4'd1, 32'(p * 256 + c / 2), 2'(c / 2));
                    else            set_port(p, 4'd0, 32'h1, 2'd0);
                end
            end else if (c == 13) begin
                for (int p = 0; p < NP; p++) set_port(p, 4'd0, 32'h1, 2'd0);
            end
            tick();
        end
        idle_inputs();
        for (int c = 15; c <= 45; c++) tick();

        for (int p = 0; p < NP; p++) begin
            exp_q.delete();
            for (int k = 0; k < n_exp[p]; k++)
                exp_q.push_back({2'(p), 2'd1, 2'(k), 32'(p * 256 + k + 1)});
            foreach (got_q[i]) begin
                if (int'(got_q[i][37:36]) == p) begin
                    if (exp_q.size() == 0) check("t3_extra_resp", got_q[i], 38'h0);
                    else                   check("t3_resp", got_q[i], exp_q.pop_front());
                end
            end
            check("t3_missing_resp", exp_q.size(), 0);
        end

        check("one_resp_per_cycle", multi_hits, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
